// File: rtl/parity_scheduler.sv
// Round-robin arbiter/sequencer sharing one parity checker among NUM_REQ requesters.
// Define PARITY_SCHED_TIMEOUT_EN to build the per-job watchdog.
module parity_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  output logic [IDX_W-1:0]     rsp_id,
  output logic                 rsp_even,
  output logic                 rsp_odd,
  output logic                 rsp_err,
  output logic                 sched_busy,
  output logic                 par_start,
  output logic [7:0]           par_data,
  input  logic                 par_busy,
  input  logic                 par_even,
  input  logic                 par_odd
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_RUN, S_COLLECT, S_RESPOND
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] last_grant_q;
  logic [IDX_W-1:0] id_q;
  logic [IDX_W-1:0] rsp_id_q;
  logic [7:0]       data_q;
  logic             even_q;
  logic             odd_q;
  logic             err_q;
  logic             rsp_valid_q;
  logic             par_start_q;
  logic             busy_q;

  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic [7:0]       win_word;
  logic             grant_ok;
  logic             tmo_hit;

  // Scan starts just after the previous winner so every requester gets a turn.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant_q) + k) % NUM_REQ;
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  assign win_word = req_data[{win_idx, 3'b000} +: 8];

  // The checker has no reset, so a grant also waits for it to go idle.
  assign grant_ok = (state_q == S_IDLE) && !par_busy && win_found && !rst;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = grant_ok && (win_idx == IDX_W'(gi));
    end
  endgenerate

`ifdef PARITY_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_q;

  // Held at zero in IDLE, so it starts from zero on every ISSUE entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (state_q == S_IDLE) begin
      tmo_q <= '0;
    end else if (state_q == S_ISSUE || state_q == S_RUN) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign tmo_hit = (state_q == S_ISSUE || state_q == S_RUN) &&
                   (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      id_q         <= '0;
      rsp_id_q     <= '0;
      data_q       <= '0;
      even_q       <= 1'b0;
      odd_q        <= 1'b0;
      err_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      par_start_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (grant_ok) begin
            data_q       <= win_word;
            id_q         <= win_idx;
            last_grant_q <= win_idx;
            par_start_q  <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE, S_RUN: begin
          if (tmo_hit) begin
            even_q      <= 1'b0;
            odd_q       <= 1'b0;
            err_q       <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
            par_start_q <= 1'b0;
            state_q     <= S_RESPOND;
          end else if (state_q == S_ISSUE && par_busy) begin
            par_start_q <= 1'b0;
            state_q     <= S_RUN;
          end else if (state_q == S_RUN && !par_busy) begin
            state_q <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          // Exactly one of the two flags must be set for a trustworthy result.
          even_q      <= par_even;
          odd_q       <= par_odd;
          err_q       <= ~(par_even ^ par_odd);
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESPOND;
        end
        S_RESPOND: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_even   = even_q;
  assign rsp_odd    = odd_q;
  assign rsp_err    = err_q;
  assign sched_busy = busy_q;
  assign par_start  = par_start_q;
  assign par_data   = data_q;

endmodule

// File: tb/tb_parity_scheduler.sv
// Randomized bench for parity_scheduler with a behavioural checker and arbitration model.
module tb_parity_scheduler;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int TO = 64;
`ifdef PARITY_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [IW-1:0]  rsp_id;
  logic           rsp_even, rsp_odd, rsp_err, sched_busy, par_start;
  logic [7:0]     par_data;
  logic           par_busy, par_even, par_odd;

  parity_scheduler #(.NUM_REQ(N), .IDX_W(IW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_even(rsp_even), .rsp_odd(rsp_odd), .rsp_err(rsp_err),
    .sched_busy(sched_busy), .par_start(par_start), .par_data(par_data),
    .par_busy(par_busy), .par_even(par_even), .par_odd(par_odd)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Scoreboard / reference state
  bit            job, raised, dead, rnd, last_start, m_active;
  int            age, g_cyc, last_grant, m_delay, m_len, grants, rsps, aborted;
  logic [7:0]    m_word, cur_word;
  logic [IW-1:0] cur_id;
  logic [4:0]    last_rsp;
  bit [N-1:0]    req_v, drop_pending;
  logic [7:0]    req_w [N];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic raise(input int i, input logic [7:0] w);
    req_v[i] = 1'b1;
    req_w[i] = w;
  endtask

  // One clock: drive inputs after negedge, then sample/check before the posedge.
  task automatic step();
    logic [N-1:0] exp_ready;
    logic [4:0]   expv;
    bit           found, to_hit, exp_start, exp_rsp;
    int           w;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (drop_pending[i]) begin
        req_v[i] = 1'b0;
        drop_pending[i] = 1'b0;
      end else if (rnd) begin
        if (!req_v[i] && $urandom_range(0, 7) == 0) begin
          req_v[i] = 1'b1;
          req_w[i] = 8'($urandom);
        end else if (req_v[i] && $urandom_range(0, 39) == 0) begin
          req_v[i] = 1'b0;
        end
      end
      req_valid[i] = req_v[i];
      req_data[8*i +: 8] = req_w[i];
    end
    // Behavioural parity checker: start -> delay -> busy for a while -> results.
    if (!m_active && last_start && !dead) begin
      m_active = 1'b1;
      m_delay  = $urandom_range(0, 2);
      m_len    = $urandom_range(0, 6);
      m_word   = par_data;
    end
    if (m_active) begin
      if (m_delay > 0) m_delay--;
      else if (!par_busy) par_busy = 1'b1;
      else if (m_len > 0) m_len--;
      else begin
        par_busy = 1'b0;
        par_even = ~^m_word;
        par_odd  = ^m_word;
        m_active = 1'b0;
      end
    end
    #1;
    exp_ready = '0;
    found = 1'b0;
    if (!job && !par_busy) begin
      for (int k = 1; k <= N; k++) begin
        w = (last_grant + k) % N;
        if (!found && req_v[w]) begin
          found = 1'b1;
          exp_ready[w] = 1'b1;
        end
      end
    end
    if (exp_ready != 0 || req_ready != 0) check_eq("grant", 32'(req_ready), 32'(exp_ready));
    if (job) g_cyc++;
    to_hit = TO_EN && job && (g_cyc >= TO + 1);
    check_eq("sched_busy", 32'(sched_busy), 32'(job));
    exp_start = job && !raised && !to_hit;
    if (exp_start || par_start) check_eq("par_start", 32'(par_start), 32'(exp_start));
    exp_rsp = job && ((raised && age == 2) || (TO_EN && g_cyc == TO + 1));
    if (exp_rsp || rsp_valid) check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    if (exp_rsp) begin
      if (TO_EN && g_cyc == TO + 1) expv = {cur_id, 3'b001};
      else expv = {cur_id, ~^cur_word, ^cur_word, 1'b0};
      if (rsp_valid) begin
        check_eq("rsp_fields", 32'({rsp_id, rsp_even, rsp_odd, rsp_err}), 32'(expv));
        check_eq("par_data", 32'(par_data), 32'(cur_word));
      end
      $display("rsp id=%0d word=0x%02h even=%0d odd=%0d err=%0d", rsp_id, cur_word, rsp_even, rsp_odd, rsp_err);
      last_rsp = expv;
      rsps++;
      job = 1'b0;
    end else if (!rsp_valid) begin
      check_eq("rsp_hold", 32'({rsp_id, rsp_even, rsp_odd, rsp_err}), 32'(last_rsp));
    end
    if (job && par_busy) raised = 1'b1;
    if (job && raised && !par_busy) age++;
    last_start = par_start;
    for (int i = 0; i < N; i++) begin
      if (exp_ready[i]) begin
        cur_id   = IW'(i);
        cur_word = req_w[i];
        drop_pending[i] = 1'b1;
        last_grant = i;
        grants++;
        job = 1'b1; raised = 1'b0; age = 0; g_cyc = 0;
        $display("grant req=%0d word=0x%02h", i, req_w[i]);
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd0);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_busy"}, 32'(sched_busy), 32'd0);
    check_eq({tag, "_start"}, 32'(par_start), 32'd0);
    check_eq({tag, "_data"}, 32'(par_data), 32'd0);
    check_eq({tag, "_fields"}, 32'({rsp_id, rsp_even, rsp_odd, rsp_err}), 32'd0);
  endtask

  // Asynchronous reset pulse placed between a sample point and the next posedge.
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_outputs_zero(tag);
    @(posedge clk);
    #2 rst = 1'b0;
    if (job) aborted++;
    job = 1'b0; raised = 1'b0; age = 0; g_cyc = 0;
    last_grant = N - 1; last_rsp = '0; last_start = 1'b0;
    $display("reset %s", tag);
  endtask

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    while ((job || req_v != 0 || drop_pending != 0 || m_active) && cyc < 400) begin
      step();
      cyc++;
    end
    check_eq(tag, 32'(job || req_v != 0 || m_active), 32'd0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    req_valid = '0; req_data = '0;
    par_busy = 1'b0; par_even = 1'b0; par_odd = 1'b0;
    job = 0; raised = 0; dead = 0; rnd = 0; last_start = 0; m_active = 0;
    age = 0; g_cyc = 0; last_grant = N - 1; m_delay = 0; m_len = 0;
    grants = 0; rsps = 0; aborted = 0;
    m_word = '0; cur_word = '0; cur_id = '0; last_rsp = '0;
    req_v = '0; drop_pending = '0;
    for (int i = 0; i < N; i++) req_w[i] = '0;

    repeat (2) @(negedge clk);
    #1 check_outputs_zero("por");
    @(posedge clk);
    #2 rst = 1'b0;

    raise(0, 8'hA5);
    wait_idle("a5_done");
    raise(2, 8'h07);
    wait_idle("07_done");

    step();
    do_reset("pre_all4");
    raise(0, 8'h00); raise(1, 8'h01); raise(2, 8'h03); raise(3, 8'hFF);
    wait_idle("all4_done");

    raise(1, 8'h5C);
    wait_idle("r1_done");
    raise(0, 8'h11); raise(3, 8'h33);
    wait_idle("r0r3_done");

    raise(0, 8'h5A);
    cyc = 0;
    while (!raised && cyc < 20) begin
      step();
      cyc++;
    end
    check_eq("reached_run", 32'(raised), 32'd1);
    raise(3, 8'hC3);
    step();
    do_reset("mid_run");
    wait_idle("after_rst_done");

    dead = 1'b1;
    raise(1, 8'h3C);
    repeat (80) step();
    check_eq("stall_job_open", 32'(job), 32'(!TO_EN));
    do_reset("after_stall");
    dead = 1'b0;

    rnd = 1'b1;
    repeat (600) step();
    rnd = 1'b0;
    wait_idle("random_drain");

    check_eq("rsp_count", 32'(rsps), 32'(grants - aborted));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/parity_scheduler.md
Name: parity_scheduler

Overview:
Round-robin arbiter and sequencer that shares one `parity` checker among NUM_REQ requesters. It accepts an 8-bit word from the granted requester and drives the checker's start/busy handshake. It then collects even_parity/odd_parity and returns a tagged one-cycle response. It sits between the Caravel-side request logic and the single `parity` instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDX_W, 2, requester index width, equal to clog2(NUM_REQ)
TIMEOUT_CYCLES, 64, watchdog limit per job; must exceed checker worst case (~30 cycles)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request, held until accepted
req_data  in  8*NUM_REQ  word for requester i at bits [8i+7:8i]
req_ready  out  NUM_REQ  one-hot accept pulse, combinational in IDLE
rsp_valid  out  1  one-cycle response strobe
rsp_id  out  IDX_W  requester index of response
rsp_even  out  1  captured even_parity
rsp_odd  out  1  captured odd_parity
rsp_err  out  1  response invalid (bad result or timeout)
sched_busy  out  1  high whenever state != IDLE
par_start  out  1  to checker start
par_data  out  8  to checker data_in, held for the whole job
par_busy  in  1  from checker busy
par_even  in  1  from checker even_parity
par_odd  in  1  from checker odd_parity

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-high.
- Reset values:
  - All outputs 0.
  - State = IDLE.
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
  - data_q = 0; timeout counter = 0.
- States and transitions:
  - IDLE: grant only if par_busy==0 and any req_valid. The checker has no reset, so this wait is required after reset.
    - Winner = first valid index scanning last_grant+1, +2, … modulo NUM_REQ.
    - req_ready[winner]=1 this cycle. At the clock edge: data_q <= winner's word, id_q <= winner, last_grant <= winner, go to ISSUE.
  - ISSUE: par_start=1. When par_busy==1, go to RUN; par_start drops in RUN.
  - RUN: par_start=0. When par_busy==0, go to COLLECT.
  - COLLECT: even_q <= par_even, odd_q <= par_odd; err_q <= ~(par_even ^ par_odd). Go to RESPOND.
  - RESPOND: rsp_valid=1 for exactly one cycle, with rsp_id=id_q, rsp_even/rsp_odd/rsp_err from registers. Go to IDLE.
- rsp_* outputs are registered and hold their last value when rsp_valid=0.
- par_data = data_q in every state.
- Minimum issue-to-issue spacing: RESPOND→IDLE adds one cycle.
- A requester that drops req_valid before being granted is skipped; no response is generated for it.
- req_valid asserted during a job is queued naturally and arbitrated in the next IDLE.
- Only one job is ever outstanding; requesters must not change req_data while req_valid is high and not yet accepted.
- Round-robin wrap: after granting NUM_REQ-1, the scan restarts at 0.
- rst mid-job:
  - Immediate return to IDLE, par_start=0, no response for the aborted job.
  - The checker finishes on its own; IDLE waits for par_busy==0 before the next grant.
- Spurious par_busy rise while in IDLE is ignored.

Optional Feature:
Macro PARITY_SCHED_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to ISSUE and increments each cycle in ISSUE or RUN.
  - On reaching TIMEOUT_CYCLES: go to RESPOND with rsp_err=1, rsp_even=0, rsp_odd=0, par_start=0.
  - The next grant still requires par_busy==0.
- Not defined: no counter is built; ISSUE and RUN wait indefinitely, and rsp_err reflects only the bad-result check.

Test Plan:
- Requester 0 sends 0xA5, no other traffic -> req_ready[0] one pulse; par_start held until par_busy rises; rsp_valid once, rsp_id=0, rsp_even=1, rsp_odd=0, rsp_err=0.
- Requester 2 sends 0x07 -> rsp_id=2, rsp_odd=1, rsp_even=0.
- All four requesters valid simultaneously after reset, words 0x00/0x01/0x03/0xFF -> grant order 0,1,2,3; responses even, odd, even, even; no overlapping jobs.
- Requester 1 granted last, then requesters 0 and 3 both valid -> 3 granted before 0.
- rst pulsed mid-RUN -> outputs 0 immediately, no rsp_valid; a pending request is granted only after par_busy falls; it completes correctly.
- With PARITY_SCHED_TIMEOUT_EN, checker model never raises par_busy -> rsp_valid with rsp_err=1 exactly 64 cycles after ISSUE entry. Without the macro, the FSM stays in ISSUE.
